gate_op_scheduler: RTL and testbench

- Round-robin scheduler that shares one logic_gates datapath (inputs a, b; outputs and/or/nand/nor/notb/xor/xnor) between NUM_REQ requesters.
- Accepts one request at a time over a valid/ready handshake and drives the shared gate operands from registers.
- Selects the requested gate output and returns it with the requester ID over a valid/ready response channel.
- Sits between the requester logic and the single logic_gates instance.

---
 rtl/gate_op_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_gate_op_scheduler.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : gate_op_scheduler
//  Description : Round-robin scheduler sharing one logic_gates datapath
//                between NUM_REQ requesters. Requests are accepted one at a
//                time, the shared operands are driven from registers, and the
//                selected gate result is returned with the requester ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_op_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [3*NUM_REQ-1:0]   req_op,
    input  logic [NUM_REQ-1:0]     req_a,
    input  logic [NUM_REQ-1:0]     req_b,
    output logic                   gate_a,
    output logic                   gate_b,
    input  logic                   gate_and,
    input  logic                   gate_or,
    input  logic                   gate_nand,
    input  logic                   gate_nor,
    input  logic                   gate_notb,
    input  logic                   gate_xor,
    input  logic                   gate_xnor,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [2:0]             rsp_op,
    output logic                   rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_RESP  = 2'd2;

    localparam logic [2:0] c_OP_RSVD  = 3'd7;
    localparam logic [ID_W-1:0]  c_LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]    c_NUM_REQ  = (ID_W+1)'(NUM_REQ);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  r_id;
    logic [2:0]       r_op;

    logic             w_found;
    logic [ID_W-1:0]  w_grant_id;
    logic [ID_W:0]    w_sum;
    logic [2:0]       w_sel_op;
    logic             w_sel_a;
    logic             w_sel_b;
    logic             w_accept;
    logic             w_gate_res;

    // Rotating priority search starting one past the last granted requester
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_sum      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_sum = {1'b0, r_last_grant} + (ID_W+1)'(k);
            if (w_sum >= c_NUM_REQ) begin
                w_sum = w_sum - c_NUM_REQ;
            end
            if (!w_found && req_valid[w_sum[ID_W-1:0]]) begin
                w_found    = 1'b1;
                w_grant_id = w_sum[ID_W-1:0];
            end
        end
    end

    // Route the winning requester's opcode and operands
    always_comb begin
        w_sel_op = '0;
        w_sel_a  = 1'b0;
        w_sel_b  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == w_grant_id) begin
                w_sel_op = req_op[3*i +: 3];
                w_sel_a  = req_a[i];
                w_sel_b  = req_b[i];
            end
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_accept)  w_state_next = c_ST_ISSUE;
            c_ST_ISSUE: w_state_next = c_ST_RESP;
            c_ST_RESP:  if (rsp_ready) w_state_next = c_ST_IDLE;
            default:    w_state_next = c_ST_IDLE;
        endcase
    end

    // Output logic: one-hot grant only while idle and out of reset
    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == c_ST_IDLE) && w_found) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_ready[i] = (ID_W'(i) == w_grant_id);
            end
        end
    end

    assign w_accept = |(req_valid & req_ready);

    // Select the shared gate output named by the latched opcode
    always_comb begin
        w_gate_res = 1'b0;
        case (r_op)
            3'd0:    w_gate_res = gate_and;
            3'd1:    w_gate_res = gate_or;
            3'd2:    w_gate_res = gate_nand;
            3'd3:    w_gate_res = gate_nor;
            3'd4:    w_gate_res = gate_notb;
            3'd5:    w_gate_res = gate_xor;
            3'd6:    w_gate_res = gate_xnor;
            default: w_gate_res = 1'b0;
        endcase
    end

    // Transaction datapath: latch on accept, capture result in ISSUE, retire in RESP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= c_LAST_RST;
            r_id         <= '0;
            r_op         <= '0;
            gate_a       <= 1'b0;
            gate_b       <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_op       <= '0;
            rsp_data     <= 1'b0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            busy <= (w_state_next != c_ST_IDLE);
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_id         <= w_grant_id;
                        r_op         <= w_sel_op;
                        gate_a       <= w_sel_a;
                        gate_b       <= w_sel_b;
                        r_last_grant <= w_grant_id;
                    end
                end
                c_ST_ISSUE: begin
                    rsp_id    <= r_id;
                    rsp_op    <= r_op;
                    rsp_data  <= w_gate_res;
                    rsp_err   <= (r_op == c_OP_RSVD);
                    rsp_valid <= 1'b1;
                end
                c_ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_op_scheduler
//  Description : Scoreboard bench for gate_op_scheduler with a behavioural
//                logic_gates model and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_op_scheduler;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [3*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0] req_a;
    logic [NUM_REQ-1:0] req_b;
    logic gate_a, gate_b;
    logic gate_and, gate_or, gate_nand, gate_nor, gate_notb, gate_xor, gate_xnor;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [ID_W-1:0]    rsp_id;
    logic [2:0]         rsp_op;
    logic               rsp_data;
    logic               rsp_err;
    logic               busy;

    gate_op_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .gate_a(gate_a), .gate_b(gate_b),
        .gate_and(gate_and), .gate_or(gate_or), .gate_nand(gate_nand),
        .gate_nor(gate_nor), .gate_notb(gate_notb), .gate_xor(gate_xor),
        .gate_xnor(gate_xnor),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // Behavioural shared logic_gates instance
    assign gate_and  = gate_a & gate_b;
    assign gate_or   = gate_a | gate_b;
    assign gate_nand = ~(gate_a & gate_b);
    assign gate_nor  = ~(gate_a | gate_b);
    assign gate_notb = ~gate_b;
    assign gate_xor  = gate_a ^ gate_b;
    assign gate_xnor = ~(gate_a ^ gate_b);

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [2:0]      op;
        logic            data;
        logic            err;
    } rsp_t;

    rsp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference model state: 0 = free, 1 = computing, 2 = response offered
    int   m_phase = 0;
    int   m_last  = NUM_REQ - 1;
    logic m_ga = 1'b0;
    logic m_gb = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic truth(input logic [2:0] op, input logic a, input logic b);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return !(a & b);
            3'd3: return !(a | b);
            3'd4: return !b;
            3'd5: return a ^ b;
            3'd6: return a == b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int last);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Reference model advances on each clock edge; reset discards everything
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_last  = NUM_REQ - 1;
            m_ga    = 1'b0;
            m_gb    = 1'b0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: begin
                    int w;
                    w = pick(req_valid, m_last);
                    if (w >= 0) begin
                        rsp_t e;
                        logic [2:0] op;
                        op     = req_op[3*w +: 3];
                        e.id   = ID_W'(w);
                        e.op   = op;
                        e.data = truth(op, req_a[w], req_b[w]);
                        e.err  = (op == 3'd7);
                        exp_q.push_back(e);
                        m_ga    = req_a[w];
                        m_gb    = req_b[w];
                        m_last  = w;
                        m_phase = 1;
                    end
                end
                1: m_phase = 2;
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    // Monitor: cycle checks against the model and scoreboard pop on handshake
    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs",
                {20'd0, req_ready, gate_a, gate_b, rsp_valid, rsp_id, rsp_op, rsp_data, rsp_err, busy},
                32'd0);
        end else begin
            int w;
            logic [NUM_REQ-1:0] er;
            w  = pick(req_valid, m_last);
            er = '0;
            if (m_phase == 0 && w >= 0) er[w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(er));
            chk("busy", 32'(busy), 32'(m_phase != 0));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            chk("gate_ab", {30'd0, gate_a, gate_b}, {30'd0, m_ga, m_gb});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_id), 32'hFFFF_FFFF);
                end else begin
                    rsp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_fields", 32'({rsp_id, rsp_op, rsp_data, rsp_err}), 32'(e));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic [2:0] op, input logic a, input logic b);
        req_valid[r]     = 1'b1;
        req_op[3*r +: 3] = op;
        req_a[r]         = a;
        req_b[r]         = b;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        cyc(3);
        @(negedge clk) rst = 1'b0;
        cyc(1);

        // Single requester, XOR with a=1 b=0
        rsp_ready = 1'b1;
        drive(1, 3'd5, 1'b1, 1'b0);
        cyc(1);
        req_valid = '0;
        cyc(4);

        // All requesters held valid: strict rotation
        for (int i = 0; i < NUM_REQ; i++) drive(i, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
        cyc(18);
        req_valid = '0;
        cyc(4);

        // Response back-pressure
        rsp_ready = 1'b0;
        drive(0, 3'd2, 1'b1, 1'b1);
        cyc(1);
        req_valid = '0;
        drive(3, 3'd3, 1'b0, 1'b0);
        cyc(7);
        rsp_ready = 1'b1;
        cyc(4);
        req_valid = '0;
        cyc(4);

        // Full opcode / operand sweep from requester 2
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                drive(2, 3'(op), 1'(ab >> 1), 1'(ab));
                cyc(1);
                req_valid = '0;
                cyc(3);
            end
        end

        // Requester 3 pulses while busy and withdraws before idle
        drive(0, 3'd1, 1'b0, 1'b1);
        cyc(1);
        req_valid = '0;
        drive(3, 3'd0, 1'b1, 1'b1);
        cyc(1);
        req_valid = '0;
        cyc(4);

        // Reset during ISSUE of requester 2, then 0 and 2 together
        drive(2, 3'd0, 1'b1, 1'b1);
        cyc(1);
        req_valid = '0;
        #1 rst = 1'b1;
        #1 chk("async_reset_now",
               {21'd0, gate_a, gate_b, rsp_valid, rsp_id, rsp_op, rsp_data, rsp_err, busy}, 32'd0);
        cyc(2);
        @(negedge clk) rst = 1'b0;
        cyc(1);
        drive(0, 3'd6, 1'b1, 1'b0);
        drive(2, 3'd4, 1'b0, 1'b0);
        cyc(1);
        req_valid = '0;
        cyc(8);

        // Randomised traffic with random back-pressure
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_valid[i]     = ($urandom_range(0, 2) == 0);
                req_op[3*i +: 3] = 3'($urandom_range(0, 7));
                req_a[i]         = 1'($urandom);
                req_b[i]         = 1'($urandom);
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            cyc(1);
        end

        req_valid = '0;
        rsp_ready = 1'b1;
        cyc(8);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
